// File: rtl/step_conditioner.sv
// Pushbutton conditioner: synchronizes and debounces a raw button, then issues
// one-cycle step strobes with optional hold-to-auto-repeat and a running step count.
module step_conditioner #(
   parameter int unsigned DEBOUNCE_CYC = 50000,
   parameter int unsigned HOLD_CYC     = 25000000,
   parameter int unsigned REPEAT_CYC   = 5000000,
   parameter int unsigned CNT_W        = 25
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_raw,
   input  logic       auto_en,
   output logic       step_pulse,
   output logic       btn_level,
   output logic [7:0] step_count
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HOLD,
      ST_REPEAT
   } state_t;

   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);

   logic             r_sync0;
   logic             r_sync1;
   logic [CNT_W-1:0] r_db_cnt;
   logic             r_level;
   state_t           r_state;
   logic [CNT_W-1:0] r_timer;
   logic             r_pulse;
   logic [7:0]       r_count;

   logic [CNT_W-1:0] w_db_cnt_nxt;
   logic             w_level_nxt;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] w_timer_nxt;
   logic             w_pulse_nxt;

   // The FSM looks at w_level_nxt so the first strobe lands on the same edge
   // the debounced level rises, and a release beats any timer expiry.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      w_db_cnt_nxt = r_db_cnt;
      w_level_nxt  = r_level;
      if (r_sync1 == r_level) begin
         w_db_cnt_nxt = '0;
      end else if (r_db_cnt == DB_LAST) begin
         w_level_nxt  = ~r_level;
         w_db_cnt_nxt = '0;
      end else begin
         w_db_cnt_nxt = r_db_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = r_timer;
      w_pulse_nxt = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_level_nxt && !r_level) begin
               w_pulse_nxt = 1'b1;
               w_state_nxt = ST_HOLD;
               w_timer_nxt = '0;
            end
         end
         ST_HOLD: begin
            if (!w_level_nxt) begin
               w_state_nxt = ST_IDLE;
               w_timer_nxt = '0;
            end else if (!auto_en) begin
               w_timer_nxt = '0;
            end else if (r_timer == HOLD_LAST) begin
               w_pulse_nxt = 1'b1;
               w_state_nxt = ST_REPEAT;
               w_timer_nxt = '0;
            end else begin
               w_timer_nxt = r_timer + CNT_W'(1);
            end
         end
         ST_REPEAT: begin
            if (!w_level_nxt) begin
               w_state_nxt = ST_IDLE;
               w_timer_nxt = '0;
            end else if (!auto_en) begin
               w_state_nxt = ST_HOLD;
               w_timer_nxt = '0;
            end else if (r_timer == REP_LAST) begin
               w_pulse_nxt = 1'b1;
               w_timer_nxt = '0;
            end else begin
               w_timer_nxt = r_timer + CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_timer_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync0  <= 1'b0;
         r_sync1  <= 1'b0;
         r_db_cnt <= '0;
         r_level  <= 1'b0;
         r_state  <= ST_IDLE;
         r_timer  <= '0;
         r_pulse  <= 1'b0;
         r_count  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values, which the synchronizer chain relies on.
         r_sync0  <= btn_raw;
         r_sync1  <= r_sync0;
         r_db_cnt <= w_db_cnt_nxt;
         r_level  <= w_level_nxt;
         r_state  <= w_state_nxt;
         r_timer  <= w_timer_nxt;
         r_pulse  <= w_pulse_nxt;
         if (w_pulse_nxt) begin
            r_count <= r_count + 8'd1;
         end
      end
   end

   assign step_pulse = r_pulse;
   assign btn_level  = r_level;
   assign step_count = r_count;

endmodule

// File: tb/tb_step_conditioner.sv
// Directed bench for step_conditioner with short timing parameters; pulse edges
// are logged per scenario and compared with hand-computed edge numbers.
module tb_step_conditioner;

   localparam int DEB  = 4;
   localparam int HOLD = 20;
   localparam int REP  = 8;
   localparam int LAT  = DEB + 2;

   logic       clk     = 1'b0;
   logic       rst_n   = 1'b1;
   logic       btn_raw = 1'b0;
   logic       auto_en = 1'b0;
   logic       step_pulse;
   logic       btn_level;
   logic [7:0] step_count;

   int   n_assert   = 0;
   int   n_fail     = 0;
   int   cyc        = 0;
   int   n_dbl      = 0;
   int   n_rise     = 0;
   int   rise_cyc   = -1;
   int   fall_cyc   = -1;
   logic prev_pulse = 1'b0;
   logic prev_level = 1'b0;
   int   pulses[$];
   int   exp_q[$];
   int   c0, c1, c2;

   step_conditioner #(
      .DEBOUNCE_CYC(DEB),
      .HOLD_CYC    (HOLD),
      .REPEAT_CYC  (REP),
      .CNT_W       (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_raw   (btn_raw),
      .auto_en   (auto_en),
      .step_pulse(step_pulse),
      .btn_level (btn_level),
      .step_count(step_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance n edges, sampling 1 time unit after each rising edge.
   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         cyc++;
         if (step_pulse === 1'b1) begin
            pulses.push_back(cyc);
            if (prev_pulse === 1'b1) n_dbl++;
         end
         prev_pulse = step_pulse;
         if (btn_level !== prev_level) begin
            if (btn_level === 1'b1) begin
               rise_cyc = cyc;
               n_rise++;
            end else begin
               fall_cyc = cyc;
            end
         end
         prev_level = btn_level;
      end
   endtask

   task automatic check_pulses(input string tag);
      check({tag, "_npulse"}, pulses.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         check({tag, "_pulse_edge"}, (i < pulses.size()) ? pulses[i] : -1, exp_q[i]);
      end
   endtask

   task automatic press();
      btn_raw = 1'b1;
      run(8);
      btn_raw = 1'b0;
      run(8);
   endtask

   initial begin
      // Reset with a toggling button: all outputs stay low.
      #1 rst_n = 1'b0;
      #1;
      check("rst_t0_pulse", step_pulse, 0);
      check("rst_t0_level", btn_level, 0);
      check("rst_t0_count", step_count, 0);
      for (int i = 0; i < 10; i++) begin
         btn_raw = ~btn_raw;
         run(1);
         check("rst_pulse", step_pulse, 0);
         check("rst_level", btn_level, 0);
         check("rst_count", step_count, 0);
      end
      btn_raw = 1'b0;
      rst_n   = 1'b1;
      run(4);

      // Clean press without auto-repeat.
      pulses.delete();
      c0 = cyc;
      btn_raw = 1'b1;
      run(15);
      btn_raw = 1'b0;
      c1 = cyc;
      run(10);
      exp_q.delete();
      exp_q.push_back(c0 + LAT);
      check_pulses("clean");
      check("clean_rise_edge", rise_cyc, c0 + LAT);
      check("clean_fall_edge", fall_cyc, c1 + LAT);
      check("clean_count", step_count, 1);

      // Glitches of 1..3 cycles never reach the debounce threshold.
      pulses.delete();
      n_rise = 0;
      btn_raw = 1'b1; run(1); btn_raw = 1'b0; run(2);
      btn_raw = 1'b1; run(2); btn_raw = 1'b0; run(2);
      btn_raw = 1'b1; run(3); btn_raw = 1'b0; run(3);
      btn_raw = 1'b1; run(3); btn_raw = 1'b0; run(2);
      check("bounce_npulse", pulses.size(), 0);
      check("bounce_nrise", n_rise, 0);
      check("bounce_level", btn_level, 0);
      c0 = cyc;
      btn_raw = 1'b1;
      run(10);
      btn_raw = 1'b0;
      run(10);
      exp_q.delete();
      exp_q.push_back(c0 + LAT);
      check_pulses("bounce_press");
      check("bounce_count", step_count, 2);

      // Auto-repeat for 60 cycles; the release lands on a REPEAT expiry edge.
      pulses.delete();
      auto_en = 1'b1;
      c0 = cyc;
      btn_raw = 1'b1;
      run(60);
      btn_raw = 1'b0;
      c1 = cyc;
      run(20);
      exp_q.delete();
      exp_q.push_back(c0 + 6);
      exp_q.push_back(c0 + 26);
      exp_q.push_back(c0 + 34);
      exp_q.push_back(c0 + 42);
      exp_q.push_back(c0 + 50);
      exp_q.push_back(c0 + 58);
      check_pulses("auto");
      check("auto_fall_at_expiry", fall_cyc, c0 + 66);
      check("auto_count", step_count, 8);

      // auto_en dropped in REPEAT returns to HOLD; the hold delay restarts.
      pulses.delete();
      c0 = cyc;
      btn_raw = 1'b1;
      run(30);
      auto_en = 1'b0;
      run(10);
      auto_en = 1'b1;
      run(30);
      btn_raw = 1'b0;
      run(10);
      exp_q.delete();
      exp_q.push_back(c0 + 6);
      exp_q.push_back(c0 + 26);
      exp_q.push_back(c0 + 60);
      exp_q.push_back(c0 + 68);
      check_pulses("pause");
      check("pause_fall_edge", fall_cyc, c0 + 76);
      check("pause_count", step_count, 12);

      // Counter wrap: 243 presses reach 255, one more wraps to 0.
      auto_en = 1'b0;
      pulses.delete();
      for (int i = 0; i < 243; i++) press();
      check("wrap_count_255", step_count, 255);
      press();
      check("wrap_count_0", step_count, 0);
      check("wrap_npulse", pulses.size(), 244);

      // Reset mid-REPEAT with the button still held.
      auto_en = 1'b1;
      c0 = cyc;
      btn_raw = 1'b1;
      run(30);
      check("mid_count_before", step_count, 2);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_pulse", step_pulse, 0);
      check("mid_rst_level", btn_level, 0);
      check("mid_rst_count", step_count, 0);
      pulses.delete();
      run(3);
      check("mid_rst_hold_level", btn_level, 0);
      check("mid_rst_hold_count", step_count, 0);
      rst_n = 1'b1;
      c2 = cyc;
      run(10);
      exp_q.delete();
      exp_q.push_back(c2 + LAT);
      check_pulses("after_rst");
      check("after_rst_rise", rise_cyc, c2 + LAT);
      check("after_rst_count", step_count, 1);
      btn_raw = 1'b0;
      run(10);

      check("no_back_to_back", n_dbl, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
